// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register scoreboard busy bits,
// same-cycle write bypass on reads, and a registered count of busy registers.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 4,
  parameter int NWR  = 2,
  parameter int NRSV = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   ra    [NRD],
  output logic [XLEN-1:0] rd    [NRD],
  output logic            rbusy [NRD],
  input  logic            we    [NWR],
  input  logic [AW-1:0]   wa    [NWR],
  input  logic [XLEN-1:0] wd    [NWR],
  input  logic            rsv_v [NRSV],
  input  logic [AW-1:0]   rsv_a [NRSV],
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] cnt;
    cnt = {(AW+1){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + {{AW{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  logic [XLEN-1:0] rf_r [NREG];
  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [NREG-1:0] set_s;
  logic [NREG-1:0] clr_s;
  logic [AW:0]     busy_cnt_r;

  // Next busy vector: reserves dominate write-clears, flush dominates both; x0 never busy.
  always_comb begin
    set_s = {NREG{1'b0}};
    clr_s = {NREG{1'b0}};
    for (int i = 0; i < NRSV; i++) begin
      set_s[rsv_a[i]] = set_s[rsv_a[i]] | rsv_v[i];
    end
    for (int k = 0; k < NWR; k++) begin
      clr_s[wa[k]] = clr_s[wa[k]] | we[k];
    end
    busy_nxt_s    = flush ? {NREG{1'b0}} : ((busy_r & ~clr_s) | set_s);
    busy_nxt_s[0] = 1'b0;
  end

  // Register file and scoreboard state; descending port loop lets the lowest port win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        rf_r[r] <= {XLEN{1'b0}};
      end
      busy_r     <= {NREG{1'b0}};
      busy_cnt_r <= {(AW+1){1'b0}};
    end else begin
      for (int k = NWR - 1; k >= 0; k--) begin
        if (we[k] && (wa[k] != {AW{1'b0}})) begin
          rf_r[wa[k]] <= wd[k];
        end
      end
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= popcount(busy_nxt_s);
    end
  end

  // Zero-latency reads with same-cycle bypass from the lowest-index hitting write port.
  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd[j]    = rf_r[ra[j]];
      rbusy[j] = busy_r[ra[j]];
      for (int k = NWR - 1; k >= 0; k--) begin
        rd[j]    = (we[k] && (wa[k] == ra[j])) ? wd[k] : rd[j];
        rbusy[j] = rbusy[j] & ~(we[k] && (wa[k] == ra[j]));
      end
      rd[j]    = (ra[j] == {AW{1'b0}}) ? {XLEN{1'b0}} : rd[j];
      rbusy[j] = (ra[j] == {AW{1'b0}}) ? 1'b0 : rbusy[j];
    end
  end

  assign busy_cnt = busy_cnt_r;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width of each register.
REQ-002 SHALL provide parameter NREG, default 32, register count including x0; AW = clog2(NREG).
REQ-003 SHALL provide parameter NRD, default 4, number of read ports.
REQ-004 SHALL provide parameter NWR, default 2, number of write ports.
REQ-005 SHALL provide parameter NRSV, default 2, number of destination-reservation ports.
REQ-006 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port ra[NRD], input, AW each, read addresses.
REQ-010 SHALL have port rd[NRD], output, XLEN each, read data.
REQ-011 SHALL have port rbusy[NRD], output, 1 each, pending-write flag for ra[j].
REQ-012 SHALL have port we[NWR], input, 1 each, write enables.
REQ-013 SHALL have port wa[NWR], input, AW each, write addresses.
REQ-014 SHALL have port wd[NWR], input, XLEN each, write data.
REQ-015 SHALL have port rsv_v[NRSV], input, 1 each, reserve-destination strobes.
REQ-016 SHALL have port rsv_a[NRSV], input, AW each, reserved register addresses.
REQ-017 SHALL have port flush, input, 1, clears all busy bits.
REQ-018 SHALL have port busy_cnt, output, AW+1, registered count of busy registers.

Function
REQ-019 SHALL read x0 as zero, ignore writes to x0, and never mark x0 busy.
REQ-020 SHALL write rf[wa[k]] <= wd[k] at the rising edge when we[k]=1 and wa[k]!=0.
REQ-021 SHALL, when several enabled write ports target the same address, let the lowest port index win.
REQ-022 SHALL drive rd[j] combinationally: 0 if ra[j]=0; otherwise wd of the lowest-index enabled write port with wa[k]=ra[j] (same-cycle bypass); otherwise rf[ra[j]].
REQ-023 SHALL hold one busy bit per register x1..x(NREG-1).
REQ-024 SHALL set busy[rsv_a[i]] at the edge when rsv_v[i]=1 and rsv_a[i]!=0.
REQ-025 SHALL clear busy[wa[k]] at the edge when we[k]=1.
REQ-026 SHALL, for a same-cycle reserve and write to one address, let the reserve win, so the bit stays/becomes 1 for the new producer.
REQ-027 SHALL, when flush=1, clear every busy bit at the edge, overriding all reserves in that cycle; register writes still occur.
REQ-028 SHALL drive rbusy[j] = busy[ra[j]] AND NOT(any enabled write hits ra[j] this cycle); rbusy[j]=0 for ra[j]=0.
REQ-029 SHALL update busy_cnt at the same edge as the busy bits, equal to the popcount of the next busy vector (0..NREG-1), with no wrap.
REQ-030 SHALL leave duplicate reserves to one address counted once.
REQ-031 SHALL make read latency 0 cycles, and make write and busy effects visible to non-bypassed reads from the next cycle.

Reset
REQ-032 SHALL, while reset=1, asynchronously force all registers to 0, all busy bits to 0, and busy_cnt to 0.
REQ-033 SHALL ignore writes, reserves and flush while reset=1, and resume normal operation at the first edge after deassertion.
REQ-034 SHALL drive rd as data 0, or bypass data, and rbusy as 0 during reset.

Verification
REQ-035 SHALL cover: reset, then read all addresses -> every rd=0, every rbusy=0, busy_cnt=0.
REQ-036 SHALL cover: we[0]=we[1]=1, wa=5/5, wd=0xAAAA/0xBBBB -> same-cycle rd(ra=5)=0xAAAA; next cycle rf[5]=0xAAAA.
REQ-037 SHALL cover: write wa=0, wd=0xFFFFFFFF -> rd(ra=0)=0 in both cycles; reserve x0 -> busy_cnt unchanged.
REQ-038 SHALL cover: reserve x3 and x7 -> busy_cnt=2; write x3 together with a reserve of x3 -> rbusy(3)=1 and busy_cnt=2; later write x7 -> busy_cnt=1.
REQ-039 SHALL cover: busy_cnt=2 with flush and rsv_a=9 in the same cycle -> busy_cnt=0 and rbusy(9)=0.
REQ-040 SHALL cover: reset asserted mid-cycle between edges with busy_cnt=3 and rf[4]=0x1234 -> immediately busy_cnt=0 and rd(ra=4)=0.
